// File: rtl/fir_ctrl.sv
// fir_ctrl: AXI-Lite register file, tap BRAM arbiter and ap_ctrl FSM
// for an FIR engine.
//
// Ports:
//   axis_clk, axis_rst_n        single clock, synchronous active-low reset
//   aw*/w*                      AXI-Lite write address/data channels
//   ar*/r*                      AXI-Lite read address/data channels
//   tap_WE/EN/Di/A/Do           tap BRAM port, 1-cycle read latency
//   eng_start                   one-cycle pulse after an accepted start write
//   eng_tap_idx                 tap index the engine reads while running
//   eng_done                    engine finished (last output handshake)
//   data_length                 configured sample count
module fir_ctrl #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   wvalid,
   output logic                   wready,
   input  logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   arvalid,
   output logic                   arready,
   input  logic [pADDR_WIDTH-1:0] araddr,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [pDATA_WIDTH-1:0] rdata,
   output logic [3:0]             tap_WE,
   output logic                   tap_EN,
   output logic [pDATA_WIDTH-1:0] tap_Di,
   output logic [pADDR_WIDTH-1:0] tap_A,
   input  logic [pDATA_WIDTH-1:0] tap_Do,
   output logic                   eng_start,
   input  logic [3:0]             eng_tap_idx,
   input  logic                   eng_done,
   output logic [pDATA_WIDTH-1:0] data_length
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
   localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
   localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32);
   localparam logic [pADDR_WIDTH-1:0] TAP_END   =
      pADDR_WIDTH'(32 + 4 * Tape_Num);

   state_t                 state;
   logic                   rd_first;
   logic                   rd_tap;
   logic [pDATA_WIDTH-1:0] rd_buf;
   logic [pDATA_WIDTH-1:0] rd_val;
   logic [pDATA_WIDTH-1:0] ctrl_val;

   logic running;
   logic wr_possible;
   logic rd_possible;
   logic wr_start;
   logic wr_len;
   logic wr_tap;
   logic rd_tap_go;
   logic rd_ctrl;

   function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
      return (a >= TAP_BASE) && (a < TAP_END) && (a[1:0] == 2'b00);
   endfunction

   assign running = (state == RUN);

   // Ready is registered so each handshake lasts exactly one cycle;
   // a pending write blocks the read decision, pushing arready out.
   assign wr_possible = awvalid && wvalid && !awready;
   assign rd_possible = arvalid && !arready && !rvalid && !wr_possible;

   assign wr_start  = awready && (awaddr == ADDR_CTRL) && wdata[0]
                      && !running;
   assign wr_len    = awready && (awaddr == ADDR_LEN) && !running;
   assign wr_tap    = awready && is_tap(awaddr) && !running;
   assign rd_tap_go = arready && is_tap(araddr) && !running;
   assign rd_ctrl   = arready && (araddr == ADDR_CTRL);

   assign ctrl_val = {{(pDATA_WIDTH-3){1'b0}},
                      !running, (state == DONE), eng_start};

   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         (araddr == ADDR_CTRL): rd_val = ctrl_val;
         (araddr == ADDR_LEN):  rd_val = data_length;
         is_tap(araddr):        rd_val = running ? '1 : '0;
         default:               rd_val = '0;
      endcase
   end

   // Engine owns the tap port while running; otherwise the bus does.
   always_comb begin
      tap_EN = 1'b0;
      tap_WE = 4'h0;
      tap_A  = '0;
      tap_Di = '0;
      if (running) begin
         tap_EN = 1'b1;
         tap_A  = {{(pADDR_WIDTH-6){1'b0}}, eng_tap_idx, 2'b00};
      end else if (wr_tap) begin
         tap_EN = 1'b1;
         tap_WE = 4'hF;
         tap_A  = awaddr - TAP_BASE;
         tap_Di = wdata;
      end else if (rd_tap_go) begin
         tap_EN = 1'b1;
         tap_A  = araddr - TAP_BASE;
      end
   end

   // BRAM data is only valid in the first rvalid cycle; afterwards the
   // captured copy keeps rdata stable while the master stalls.
   assign rdata = (rd_first && rd_tap) ? tap_Do : rd_buf;

   always_ff @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         state       <= IDLE;
         awready     <= 1'b0;
         wready      <= 1'b0;
         arready     <= 1'b0;
         rvalid      <= 1'b0;
         rd_first    <= 1'b0;
         rd_tap      <= 1'b0;
         rd_buf      <= '0;
         eng_start   <= 1'b0;
         data_length <= '0;
      end else begin
         awready   <= wr_possible;
         wready    <= wr_possible;
         arready   <= rd_possible;
         eng_start <= wr_start;

         if (wr_len) begin
            data_length <= wdata;
         end

         if (arready) begin
            rvalid   <= 1'b1;
            rd_first <= 1'b1;
            rd_tap   <= rd_tap_go;
            rd_buf   <= rd_val;
         end else begin
            rd_first <= 1'b0;
            if (rd_first && rd_tap) begin
               rd_buf <= tap_Do;
            end
            if (rvalid && rready) begin
               rvalid <= 1'b0;
            end
         end

         unique case (state)
            IDLE: begin
               if (wr_start) state <= RUN;
            end
            RUN: begin
               if (eng_done) state <= DONE;
            end
            DONE: begin
               if (wr_start)     state <= RUN;
               else if (rd_ctrl) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameters: pADDR_WIDTH, default 12, AXI-Lite/BRAM address width; pDATA_WIDTH, default 32, data width; Tape_Num, default 11, number of taps.
REQ-002 The clock and reset ports SHALL be named and used as follows:
- axis_clk  in  1  single clock.
- axis_rst_n  in  1  reset; synchronous, active-low.
REQ-003 The AXI-Lite write ports SHALL be:
- awvalid in 1; awready out 1; awaddr in 12.
- wvalid in 1; wready out 1; wdata in 32.
REQ-004 The AXI-Lite read ports SHALL be:
- arvalid in 1; arready out 1; araddr in 12.
- rvalid out 1; rready in 1; rdata out 32.
REQ-005 The tap BRAM ports SHALL be tap_WE out 4, tap_EN out 1, tap_Di out 32, tap_A out 12, tap_Do in 32; the BRAM has 1-cycle read latency.
REQ-006 The engine ports SHALL be:
- eng_start  out  1  one-cycle start pulse.
- eng_tap_idx  in  4  tap index the engine reads.
- eng_done  in  1  pulse on the last output handshake.
- data_length  out  32  configured sample count.

Function
REQ-007 Register map: 0x00 ap_ctrl (bit0 ap_start, bit1 ap_done, bit2 ap_idle); 0x10 data_length; 0x20 + 4*k holds tap k, k=0..Tape_Num-1; any other address reads 0 and ignores writes.
REQ-008 FSM states SHALL be IDLE, RUN and DONE.
- IDLE -> RUN: on a write of 0x00 with wdata[0]=1.
- RUN -> DONE: on eng_done.
- DONE -> IDLE: on an accepted read of 0x00.
- DONE -> RUN: on a start write.
REQ-009 eng_start SHALL pulse high for exactly the cycle after the start write is accepted; ap_start reads 1 only in that cycle.
REQ-010 ap_idle SHALL be 1 in IDLE and DONE and 0 in RUN; ap_done SHALL be 1 only in DONE.
REQ-011 A start write in RUN SHALL be ignored.
REQ-012 Write handshake: awready and wready SHALL rise together for one cycle only when awvalid && wvalid are both high, and the write takes effect in that cycle; awvalid without wvalid (or the reverse) SHALL stall.
REQ-013 A tap write in IDLE/DONE SHALL drive tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x20 and tap_Di=wdata in the handshake cycle.
REQ-014 Tap and data_length writes in RUN SHALL be acknowledged but discarded.
REQ-015 Read handshake: arready SHALL pulse one cycle when arvalid is high and no read is outstanding; rvalid SHALL rise the next cycle and hold, with rdata stable, until rready.
REQ-016 A tap read in IDLE/DONE SHALL drive tap_EN=1 and tap_A=araddr-0x20 in the arready cycle, and rdata SHALL equal tap_Do in the rvalid cycle.
REQ-017 A tap read in RUN SHALL return 32'hFFFF_FFFF without accessing the BRAM.
REQ-018 In RUN the engine SHALL own the tap port: tap_EN=1, tap_WE=0, tap_A=eng_tap_idx*4.
REQ-019 When a write and a read handshake are possible in the same cycle, the write SHALL win; arready is deferred one cycle.
REQ-020 eng_done in IDLE or DONE SHALL be ignored.
REQ-021 The ap_ctrl read that clears ap_done SHALL return the pre-clear value (bit1=1, bit2=1).

Reset
REQ-022 With axis_rst_n=0 sampled at a clock edge, the block SHALL enter IDLE with:
- awready, wready, arready, rvalid, eng_start and tap_EN = 0.
- tap_WE = 0, rdata = 0, data_length = 0.
- ap_ctrl reading 0x4.
REQ-023 Reset asserted in RUN SHALL abort to IDLE with no eng_start pulse, drop any pending rvalid, and leave tap RAM contents unchanged.

Verification
REQ-024 Write data_length=600 and taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, then read them back in IDLE -> each read returns the written value; 0x10 reads 600.
REQ-025 Write 0x00=1 -> eng_start high exactly one cycle later; 0x00 reads bit2=0, bit1=0 during RUN.
REQ-026 During RUN, write 0x24=5, then read 0x24 -> read returns 0xFFFF_FFFF; after DONE, 0x24 reads -10.
REQ-027 Pulse eng_done -> 0x00 reads 0x6 once, then reads 0x4; a second start write restarts RUN.
REQ-028 Assert awvalid/wvalid and arvalid in the same cycle -> write acknowledged first, arready one cycle later; hold rready=0 for 3 cycles -> rvalid and rdata held stable.
REQ-029 Assert reset mid-RUN -> next cycle 0x00 reads 0x4 and tap contents are preserved.
